hazard_unit_gen2: RTL and testbench

- Parametrised second-generation hazard/forwarding controller for the pipelined RV32 core.
- Resolves operand forwarding for the execute stage from any of NUM_FWD_STAGES downstream stages (stage 1 = memory, nearest), with explicit x0 handling.
- Stalls for load-use hazards lasting LOAD_USE_STALLS cycles and for multi-cycle mul/div occupancy of execute lasting MDU_LATENCY cycles, via a counted FSM.
- Flushes on execute-stage redirects and keeps a saturating stall-cycle performance counter.

---
 rtl/hazard_unit_gen2.sv | 161 ++++++++++++++++
 tb/tb_hazard_unit_gen2.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/hazard_unit_gen2.sv
// Hazard and forwarding controller for the RV32 pipeline: execute-stage operand
// forwarding, load-use and mul/div stalls, redirect flushes, stall-cycle counter.
module hazard_unit_gen2 #(
  parameter int NUM_FWD_STAGES  = 2,
  parameter int REG_AW          = 5,
  parameter int LOAD_USE_STALLS = 1,
  parameter int MDU_LATENCY     = 3,
  parameter int SEL_W           = $clog2(NUM_FWD_STAGES + 1)
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [REG_AW-1:0]                d_rs1,
  input  logic [REG_AW-1:0]                d_rs2,
  input  logic                             d_rs1_used,
  input  logic                             d_rs2_used,
  input  logic [REG_AW-1:0]                e_rs1,
  input  logic [REG_AW-1:0]                e_rs2,
  input  logic [REG_AW-1:0]                e_rd,
  input  logic                             e_rs1_used,
  input  logic                             e_rs2_used,
  input  logic                             e_valid,
  input  logic                             e_is_load,
  input  logic                             e_is_muldiv,
  input  logic                             e_redirect,
  input  logic [NUM_FWD_STAGES-1:0]        fwd_we,
  input  logic [NUM_FWD_STAGES*REG_AW-1:0] fwd_rd,
  input  logic [NUM_FWD_STAGES-1:0]        fwd_rdy,
  output logic [SEL_W-1:0]                 fwd_sel_a,
  output logic [SEL_W-1:0]                 fwd_sel_b,
  output logic                             pc_en,
  output logic                             f_d_en,
  output logic                             d_e_en,
  output logic                             f_d_flush,
  output logic                             d_e_flush,
  output logic                             e_m_flush,
  output logic [31:0]                      stall_count
);

  typedef enum logic [1:0] {RUN, LD_STALL, MDU_WAIT} state_t;

  localparam int LD_CNT  = (LOAD_USE_STALLS > 1) ? LOAD_USE_STALLS - 1 : 0;
  localparam int MD_CNT  = (MDU_LATENCY > 2) ? MDU_LATENCY - 2 : 0;
  localparam int CNT_MAX = (LD_CNT > MD_CNT) ? LD_CNT : MD_CNT;
  localparam int CNT_W   = $clog2(CNT_MAX + 2);

  state_t             r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_mdu_ack;
  logic [31:0]        r_stall_count;

  state_t             w_next;
  logic [CNT_W-1:0]   w_cnt_nxt;
  logic               w_ack_set;
  logic               w_ld_haz;
  logic               w_mdu_haz;
  logic               w_ld_stall;
  logic               w_mdu_stall;
  logic               w_redirect;

  // Nearest matching stage wins; if that stage is not ready, no older stage is used.
  function automatic logic [SEL_W-1:0] fwd_pick(
    input logic                             used,
    input logic [REG_AW-1:0]                rs,
    input logic [NUM_FWD_STAGES-1:0]        we,
    input logic [NUM_FWD_STAGES*REG_AW-1:0] rd,
    input logic [NUM_FWD_STAGES-1:0]        rdy
  );
    logic [SEL_W-1:0] sel;
    logic             found;
    sel   = '0;
    found = 1'b0;
    if (used && (rs != '0)) begin
      for (int k = 0; k < NUM_FWD_STAGES; k++) begin
        if (!found && we[k] && (rd[k*REG_AW +: REG_AW] == rs)) begin
          found = 1'b1;
          if (rdy[k]) sel = SEL_W'(k + 1);
        end
      end
    end
    return sel;
  endfunction

  assign fwd_sel_a = rst ? '0 : fwd_pick(e_rs1_used, e_rs1, fwd_we, fwd_rd, fwd_rdy);
  assign fwd_sel_b = rst ? '0 : fwd_pick(e_rs2_used, e_rs2, fwd_we, fwd_rd, fwd_rdy);

  assign w_ld_haz  = e_valid && e_is_load && (e_rd != '0) &&
                     ((d_rs1_used && (d_rs1 == e_rd)) || (d_rs2_used && (d_rs2 == e_rd)));
  assign w_mdu_haz = e_valid && e_is_muldiv && (MDU_LATENCY > 1) && !r_mdu_ack;

  always_comb begin
    w_next      = r_state;
    w_cnt_nxt   = r_cnt;
    w_ack_set   = 1'b0;
    w_ld_stall  = 1'b0;
    w_mdu_stall = 1'b0;
    w_redirect  = 1'b0;
    if (!rst) begin
      case (r_state)
        RUN: begin
          if (e_redirect) begin
            w_redirect = 1'b1;
          end else if (w_mdu_haz) begin
            w_mdu_stall = 1'b1;
            if (MDU_LATENCY > 2) begin
              w_next    = MDU_WAIT;
              w_cnt_nxt = CNT_W'(MD_CNT);
            end else begin
              w_ack_set = 1'b1;
            end
          end else if (w_ld_haz) begin
            w_ld_stall = 1'b1;
            if (LOAD_USE_STALLS > 1) begin
              w_next    = LD_STALL;
              w_cnt_nxt = CNT_W'(LD_CNT);
            end
          end
        end
        LD_STALL: begin
          w_ld_stall = 1'b1;
          w_cnt_nxt  = r_cnt - CNT_W'(1);
          if (r_cnt == CNT_W'(1)) w_next = RUN;
        end
        MDU_WAIT: begin
          w_mdu_stall = 1'b1;
          w_cnt_nxt   = r_cnt - CNT_W'(1);
          if (r_cnt == CNT_W'(1)) begin
            w_next    = RUN;
            w_ack_set = 1'b1;
          end
        end
        default: w_next = RUN;
      endcase
    end
  end

  assign pc_en     = !(w_ld_stall || w_mdu_stall);
  assign f_d_en    = !(w_ld_stall || w_mdu_stall);
  assign d_e_en    = !w_mdu_stall;
  assign f_d_flush = w_redirect;
  assign d_e_flush = w_redirect || w_ld_stall;
  assign e_m_flush = w_mdu_stall;
  assign stall_count = r_stall_count;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= RUN;
      r_cnt         <= '0;
      r_mdu_ack     <= 1'b0;
      r_stall_count <= '0;
    end else begin
      r_state <= w_next;
      r_cnt   <= w_cnt_nxt;
      // ack lets the finished mul/div leave execute once without re-stalling
      if (w_ack_set)   r_mdu_ack <= 1'b1;
      else if (d_e_en) r_mdu_ack <= 1'b0;
      if (!pc_en && (r_stall_count != 32'hFFFF_FFFF))
        r_stall_count <= r_stall_count + 32'd1;
    end
  end

endmodule

// File: tb/tb_hazard_unit_gen2.sv
// Directed bench for hazard_unit_gen2 with 2 forwarding stages, 2-cycle load-use
// stalls and a 4-cycle mul/div unit.
module tb_hazard_unit_gen2;

  localparam int NFS   = 2;
  localparam int AW    = 5;
  localparam int SEL_W = $clog2(NFS + 1);

  logic              clk = 1'b0;
  logic              rst;
  logic [AW-1:0]     d_rs1, d_rs2, e_rs1, e_rs2, e_rd;
  logic              d_rs1_used, d_rs2_used, e_rs1_used, e_rs2_used;
  logic              e_valid, e_is_load, e_is_muldiv, e_redirect;
  logic [NFS-1:0]    fwd_we, fwd_rdy;
  logic [NFS*AW-1:0] fwd_rd;
  logic [SEL_W-1:0]  fwd_sel_a, fwd_sel_b;
  logic              pc_en, f_d_en, d_e_en, f_d_flush, d_e_flush, e_m_flush;
  logic [31:0]       stall_count;

  int tests  = 0;
  int failed = 0;

  localparam logic [5:0] RUNV = 6'b111000;
  localparam logic [5:0] LDV  = 6'b001010;
  localparam logic [5:0] MDV  = 6'b000001;
  localparam logic [5:0] RDV  = 6'b111110;

  hazard_unit_gen2 #(
    .NUM_FWD_STAGES(NFS), .REG_AW(AW), .LOAD_USE_STALLS(2), .MDU_LATENCY(4)
  ) dut (
    .clk(clk), .rst(rst),
    .d_rs1(d_rs1), .d_rs2(d_rs2), .d_rs1_used(d_rs1_used), .d_rs2_used(d_rs2_used),
    .e_rs1(e_rs1), .e_rs2(e_rs2), .e_rd(e_rd),
    .e_rs1_used(e_rs1_used), .e_rs2_used(e_rs2_used),
    .e_valid(e_valid), .e_is_load(e_is_load), .e_is_muldiv(e_is_muldiv),
    .e_redirect(e_redirect),
    .fwd_we(fwd_we), .fwd_rd(fwd_rd), .fwd_rdy(fwd_rdy),
    .fwd_sel_a(fwd_sel_a), .fwd_sel_b(fwd_sel_b),
    .pc_en(pc_en), .f_d_en(f_d_en), .d_e_en(d_e_en),
    .f_d_flush(f_d_flush), .d_e_flush(d_e_flush), .e_m_flush(e_m_flush),
    .stall_count(stall_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_ctl(input string tag, input logic [5:0] exp);
    chk(tag, {26'd0, pc_en, f_d_en, d_e_en, f_d_flush, d_e_flush, e_m_flush}, {26'd0, exp});
  endtask

  task automatic clear_inputs();
    d_rs1 = '0; d_rs2 = '0; d_rs1_used = 1'b0; d_rs2_used = 1'b0;
    e_rs1 = '0; e_rs2 = '0; e_rd = '0; e_rs1_used = 1'b0; e_rs2_used = 1'b0;
    e_valid = 1'b0; e_is_load = 1'b0; e_is_muldiv = 1'b0; e_redirect = 1'b0;
    fwd_we = '0; fwd_rd = '0; fwd_rdy = '0;
  endtask

  // inputs change just after a falling edge; outputs are checked 1ns later
  task automatic next_cycle();
    @(negedge clk);
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    clear_inputs();
    rst = 1'b1;
    e_valid = 1'b1; e_is_muldiv = 1'b1;
    e_rs1 = 5'd5; e_rs1_used = 1'b1; fwd_we = 2'b01; fwd_rd = {5'd0, 5'd5}; fwd_rdy = 2'b01;
    next_cycle(); settle();
    chk_ctl("reset_ctl_forced", RUNV);
    chk("reset_fwd_forced", 32'(fwd_sel_a), 32'd0);
    next_cycle();
    rst = 1'b0;
    clear_inputs();
    settle();
    chk("reset_stall_count", stall_count, 32'd0);
    chk_ctl("idle_ctl", RUNV);

    e_rs1 = 5'd5; e_rs1_used = 1'b1;
    fwd_we = 2'b11; fwd_rd = {5'd5, 5'd5}; fwd_rdy = 2'b11;
    settle();
    chk("fwd_a_nearest", 32'(fwd_sel_a), 32'd1);
    fwd_we = 2'b10; settle();
    chk("fwd_a_stage2", 32'(fwd_sel_a), 32'd2);
    fwd_we = 2'b11; e_rs1 = 5'd0; fwd_rd = {5'd0, 5'd0}; settle();
    chk("fwd_a_x0", 32'(fwd_sel_a), 32'd0);
    e_rs1 = 5'd5; fwd_rd = {5'd5, 5'd5}; e_rs1_used = 1'b0; settle();
    chk("fwd_a_unused", 32'(fwd_sel_a), 32'd0);
    e_rs1_used = 1'b0;
    e_rs2 = 5'd7; e_rs2_used = 1'b1; fwd_rd = {5'd7, 5'd7}; fwd_rdy = 2'b10; settle();
    chk("fwd_b_no_fallthrough", 32'(fwd_sel_b), 32'd0);
    fwd_we = 2'b10; settle();
    chk("fwd_b_stage2", 32'(fwd_sel_b), 32'd2);
    clear_inputs();

    next_cycle();
    e_valid = 1'b1; e_is_load = 1'b1; e_rd = 5'd3; d_rs1 = 5'd3; d_rs1_used = 1'b1;
    settle();
    chk_ctl("ld_stall_c1", LDV);
    next_cycle();
    e_valid = 1'b0; settle();
    chk_ctl("ld_stall_c2", LDV);
    next_cycle();
    clear_inputs(); settle();
    chk_ctl("ld_release", RUNV);
    chk("ld_stall_count", stall_count, 32'd2);

    e_valid = 1'b1; e_is_muldiv = 1'b1; settle();
    chk_ctl("mdu_c1", MDV);
    next_cycle(); settle();
    chk_ctl("mdu_c2", MDV);
    next_cycle(); settle();
    chk_ctl("mdu_c3", MDV);
    next_cycle(); settle();
    chk_ctl("mdu_release", RUNV);
    chk("mdu_stall_count", stall_count, 32'd5);
    next_cycle(); settle();
    chk_ctl("mdu2_c1", MDV);
    next_cycle();
    e_redirect = 1'b1; settle();
    chk_ctl("mdu2_redirect_ignored", MDV);
    next_cycle();
    e_redirect = 1'b0; settle();
    chk_ctl("mdu2_c3", MDV);
    next_cycle(); settle();
    chk_ctl("mdu2_release", RUNV);
    chk("mdu2_stall_count", stall_count, 32'd8);

    next_cycle();
    clear_inputs();
    e_valid = 1'b1; e_is_load = 1'b1; e_rd = 5'd3; d_rs2 = 5'd3; d_rs2_used = 1'b1;
    e_redirect = 1'b1; settle();
    chk_ctl("redirect_over_load", RDV);
    next_cycle();
    clear_inputs(); settle();
    chk_ctl("redirect_no_ld_stall", RUNV);
    chk("redirect_stall_count", stall_count, 32'd8);

    e_valid = 1'b1; e_is_muldiv = 1'b1; settle();
    chk_ctl("rstmdu_c1", MDV);
    next_cycle(); settle();
    chk_ctl("rstmdu_c2", MDV);
    chk("rstmdu_count_pre", stall_count, 32'd9);
    rst = 1'b1; settle();
    chk_ctl("rstmdu_forced", RUNV);
    next_cycle();
    rst = 1'b0; clear_inputs(); settle();
    chk_ctl("post_rst_run", RUNV);
    chk("post_rst_count", stall_count, 32'd0);
    next_cycle(); settle();
    chk_ctl("post_rst_idle", RUNV);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
